// File: rtl/instruction_mem_loader_if.sv
// Byte-stream intake and instruction-memory write port of the program loader.
// The master modport is the loader side; slave is the byte source / memory side.
interface instruction_mem_loader_if #(
    parameter int unsigned ADDRESS_LEN = 32
);
    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   byte_ready;
    logic                   mem_we;
    logic [ADDRESS_LEN-1:0] mem_addr;
    logic [ADDRESS_LEN-1:0] mem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instruction_mem_loader.sv
// Program loader: packs a little-endian byte stream into 32-bit words and writes
// them to consecutive instruction-memory words while holding the fetch stage frozen.
module instruction_mem_loader #(
    parameter int unsigned               ADDRESS_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0]    BASE_ADDR   = '0,
    parameter int unsigned               MAX_WORDS   = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         load_end,
    instruction_mem_loader_if.master     bus,
    output logic                         freeze,
    output logic                         done,
    output logic [15:0]                  words_loaded
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t              state;
    state_t              state_nx;
    logic [1:0]          byte_cnt;
    logic [WORD_W-1:0]   asm_word;
    logic [WORD_W-1:0]   asm_nx;
    logic [CNT_W-1:0]    word_idx;
    logic                end_pend;
    logic                accept;
    logic                last_word;
    logic                byte_ready_d;
    logic                mem_we_d;
    logic                freeze_d;
    logic                done_d;

    // Byte acceptance and the assembly word including the byte taken this cycle
    always_comb begin
        accept    = bus.byte_ready & bus.byte_valid;
        last_word = (words_loaded + CNT_W'(1)) == CNT_W'(MAX_WORDS);
        asm_nx    = asm_word;
        if (accept) begin
            asm_nx[{byte_cnt, 3'b000} +: 8] = bus.byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                if (load_end) begin
                    state_nx = (byte_cnt == 2'd0 && !accept) ? DONE : WRITE;
                end else if (accept && byte_cnt == 2'd3) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                state_nx = (end_pend || last_word) ? DONE : LOAD;
            end
            DONE: begin
                if (start) state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear as registers
    always_comb begin
        byte_ready_d = 1'b0;
        mem_we_d     = 1'b0;
        freeze_d     = 1'b0;
        done_d       = 1'b0;
        case (state_nx)
            LOAD:    begin byte_ready_d = 1'b1; freeze_d = 1'b1; end
            WRITE:   begin mem_we_d     = 1'b1; freeze_d = 1'b1; end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            freeze         <= 1'b0;
            done           <= 1'b0;
        end else begin
            bus.byte_ready <= byte_ready_d;
            bus.mem_we     <= mem_we_d;
            freeze         <= freeze_d;
            done           <= done_d;
            // Address and data are latched on WRITE entry and held through DONE
            if (state == LOAD && state_nx == WRITE) begin
                bus.mem_addr  <= BASE_ADDR + ADDRESS_LEN'({word_idx, 2'b00});
                bus.mem_wdata <= ADDRESS_LEN'(asm_nx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt     <= '0;
            asm_word     <= '0;
            word_idx     <= '0;
            words_loaded <= '0;
            end_pend     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        byte_cnt     <= '0;
                        asm_word     <= '0;
                        word_idx     <= '0;
                        words_loaded <= '0;
                        end_pend     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        asm_word <= asm_nx;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    if (load_end && state_nx == WRITE) end_pend <= 1'b1;
                end
                WRITE: begin
                    word_idx     <= word_idx + CNT_W'(1);
                    words_loaded <= words_loaded + CNT_W'(1);
                    byte_cnt     <= '0;
                    asm_word     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instruction_mem_loader.md
# instruction_mem_loader

Program loader that writes the instruction memory the fetch stage reads. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to consecutive word addresses through a single-cycle write port. The fetch stage is frozen while a load is in progress.

## Interface

Parameters:
- ADDRESS_LEN, 32, width of memory address and data word
- BASE_ADDR, 0, byte address of the first word written
- MAX_WORDS, 1024, maximum number of words per load; range 1..65535

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load; honoured only in IDLE or DONE
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  program byte, least-significant byte of each word first
- load_end  in  1  end of program; honoured only in LOAD
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  ADDRESS_LEN  byte address of the write
- mem_wdata  out  ADDRESS_LEN  word written
- freeze  out  1  holds the fetch stage; high in LOAD and WRITE
- done  out  1  high in DONE
- words_loaded  out  16  words written by the current or most recent load

## Operation

- States are IDLE, LOAD, WRITE and DONE. Reset enters IDLE.
- IDLE or DONE, start=1: go to LOAD. Clear byte_cnt (2 bits), word_idx, words_loaded and the assembly register.
- LOAD: byte_ready=1.
  - A byte is accepted when byte_valid & byte_ready.
  - The accepted byte goes into bits [8·byte_cnt+7 : 8·byte_cnt] of the assembly register, and byte_cnt is incremented.
  - Accepting the 4th byte (byte_cnt==3) moves to WRITE.
- WRITE: byte_ready=0 and mem_we=1 for exactly one cycle.
  - mem_addr = BASE_ADDR + 4·word_idx, truncated to ADDRESS_LEN (wraps modulo 2^ADDRESS_LEN).
  - mem_wdata is the assembled word.
  - Next cycle: word_idx and words_loaded are incremented and byte_cnt and the assembly register are cleared.
  - If words_loaded becomes MAX_WORDS, or an end is pending, go to DONE; otherwise go to LOAD.
- load_end in LOAD:
  - byte_cnt==0 and no byte accepted: go directly to DONE with no write.
  - Partial word, or a byte accepted in the same cycle: that byte is included first, the unfilled upper bytes are zero, an end-pending flag is set, and the state goes to WRITE.
- DONE: done=1, freeze=0, byte_ready=0. mem_addr and mem_wdata hold the last write. Bytes are ignored.
- start in LOAD or WRITE is ignored. load_end outside LOAD is ignored.
- mem_we, mem_addr, mem_wdata, byte_ready, freeze and done are registered state outputs; none is combinational from inputs.

## Timing

- Reset values: state IDLE, byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, freeze 0, done 0, words_loaded 0. The assembly register, byte_cnt and word_idx are 0.
- start sampled at edge N: byte_ready=1 and freeze=1 from cycle N+1.
- 4th byte accepted at edge N: mem_we=1 in cycle N+1, byte_ready=1 again in cycle N+2. Peak throughput is 4 bytes per 5 cycles.
- words_loaded is incremented at the edge that ends the WRITE cycle.
- Final write at cycle W: done=1 and freeze=0 from cycle W+1.
- rst mid-load: at the next edge all outputs take their reset values. The partial word is discarded and no write is issued.

## Test plan

- Load 8 bytes 0x01..0x08 with start at BASE_ADDR=0, byte_valid held high:
  - mem_we pulses twice, 5 cycles apart.
  - Writes are addr 0x0 data 0x04030201, then addr 0x4 data 0x08070605.
  - words_loaded=2 and done=1; freeze is high from the cycle after start until the cycle after the last write.
- Send bytes 0xAA, 0xBB, then load_end with no byte: single write of data 0x0000BBAA at addr BASE_ADDR, then DONE with words_loaded=1.
- load_end in the same cycle as the 4th byte 0xDD of word 0 (earlier bytes 0x11, 0x22, 0x33): one write of data 0xDD332211, then DONE. There is no extra write.
- MAX_WORDS=2, 12 bytes offered:
  - Exactly 2 writes.
  - byte_ready is 0 after the second write and the remaining bytes are not accepted.
  - done=1.
- rst asserted after 2 bytes of a word:
  - No write occurs, all outputs return to reset values the next cycle, and the state is IDLE.
  - A new start then loads correctly from BASE_ADDR.
- BASE_ADDR=0xFFFFFFFC, 8 bytes: writes go to 0xFFFFFFFC, then 0x00000000 (address wraps). A start asserted during LOAD has no effect on the counters.
